// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: store buffer, store-to-load forwarding,
// fence drain, single outstanding request to the byte-serial controller.
module mem_lsu #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 17,
  parameter int SB_DEPTH = 4,
  parameter int RA_W     = 5,
  localparam int PW      = $clog2(SB_DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_valid,
  input  logic              in_ld,
  input  logic              in_st,
  input  logic              in_fence,
  input  logic [1:0]        in_size,
  input  logic              in_uns,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_sdata,
  input  logic [RA_W-1:0]   in_wd,
  input  logic              in_wreg,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              mem_busy,
  input  logic              mem_done,
  input  logic [XLEN-1:0]   mem_din,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_a,
  output logic [XLEN-1:0]   mem_dout,
  output logic [3:0]        mem_kind,
  output logic [XLEN-1:0]   mem_pc,
  output logic [RA_W-1:0]   wd_o,
  output logic              wreg_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              stallreq,
  output logic [CW-1:0]     sb_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t state, state_nx;

  logic [XLEN-1:0] sb_addr [SB_DEPTH];
  logic [1:0]      sb_size [SB_DEPTH];
  logic [XLEN-1:0] sb_data [SB_DEPTH];
  logic [XLEN-1:0] sb_pc   [SB_DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic full, pop, push, ld_done, accept;
  logic fwd_hit, hazard, fwd, load_pend;
  logic issue_ld, issue_st;
  logic [XLEN-1:0] fwd_data;
  logic [XLEN:0]   lo_l, hi_l, lo_s, hi_s;
  logic [PW-1:0]   idx;

  function automatic logic [XLEN:0] last_off(input logic [1:0] sz);
    case (sz)
      2'd0:    last_off = (XLEN+1)'(0);
      2'd1:    last_off = (XLEN+1)'(1);
      default: last_off = (XLEN+1)'(3);
    endcase
  endfunction

  function automatic logic [3:0] kind(input logic [1:0] sz);
    case (sz)
      2'd0:    kind = 4'b0001;
      2'd1:    kind = 4'b0010;
      default: kind = 4'b0100;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] ext(
    input logic [XLEN-1:0] d,
    input logic [1:0]      sz,
    input logic            uns
  );
    case (sz)
      2'd0: ext = uns ? {{(XLEN-8){1'b0}}, d[7:0]}
                      : {{(XLEN-8){d[7]}}, d[7:0]};
      2'd1: ext = uns ? {{(XLEN-16){1'b0}}, d[15:0]}
                      : {{(XLEN-16){d[15]}}, d[15:0]};
      default: ext = d;
    endcase
  endfunction

  assign sb_count = count;
  assign full     = count == CW'(SB_DEPTH);
  assign pop      = (state == DRAIN) & rdy & mem_done;
  assign ld_done  = (state == LOAD) & rdy & mem_done;

  // Scan oldest to youngest so the last covering store wins.
  // A store covers the load when bases match and it is at least as wide.
  always_comb begin
    fwd_hit  = 1'b0;
    hazard   = 1'b0;
    fwd_data = '0;
    idx      = '0;
    lo_s     = '0;
    hi_s     = '0;
    lo_l     = {1'b0, in_addr};
    hi_l     = lo_l + last_off(in_size);
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < count) begin
        lo_s = {1'b0, sb_addr[idx]};
        hi_s = lo_s + last_off(sb_size[idx]);
        if (lo_l <= hi_s && lo_s <= hi_l) begin
          if (sb_addr[idx] == in_addr &&
              in_size <= sb_size[idx]) begin
            fwd_hit  = 1'b1;
            fwd_data = sb_data[idx];
          end else begin
            hazard = 1'b1;
          end
        end
      end
    end
  end

  assign fwd       = fwd_hit & ~hazard;
  assign load_pend = in_valid & in_ld & ~fwd & ~hazard;

  always_comb begin
    stallreq = 1'b0;
    if (in_valid) begin
      unique case (1'b1)
        in_st:    stallreq = full & ~pop;
        in_ld:    stallreq = ~fwd & ~ld_done;
        in_fence: stallreq = (count != '0) | (state != IDLE);
        default:  stallreq = 1'b0;
      endcase
    end
  end

  assign accept = in_valid & rdy & ~stallreq;
  assign push   = accept & in_st;

  always_comb begin
    state_nx = state;
    issue_ld = 1'b0;
    issue_st = 1'b0;
    if (rdy) begin
      unique case (state)
        IDLE: begin
          if (!mem_busy) begin
            if (load_pend) begin
              state_nx = LOAD;
              issue_ld = 1'b1;
            end else if (count != '0) begin
              state_nx = DRAIN;
              issue_st = 1'b1;
            end
          end
        end
        LOAD:    if (mem_done) state_nx = IDLE;
        DRAIN:   if (mem_done) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[tail] <= in_addr;
      sb_size[tail] <= in_size;
      sb_data[tail] <= in_sdata;
      sb_pc[tail]   <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req  <= 1'b0;
      mem_wr   <= 1'b0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_kind <= '0;
      mem_pc   <= '0;
    end else if (rdy) begin
      if (issue_ld) begin
        mem_req  <= 1'b1;
        mem_wr   <= 1'b0;
        mem_a    <= in_addr[ADDR_W-1:0];
        mem_dout <= '0;
        mem_kind <= kind(in_size);
        mem_pc   <= in_pc;
      end else if (issue_st) begin
        mem_req  <= 1'b1;
        mem_wr   <= 1'b1;
        mem_a    <= sb_addr[head][ADDR_W-1:0];
        mem_dout <= sb_data[head];
        mem_kind <= kind(sb_size[head]);
        mem_pc   <= sb_pc[head];
      end else if (mem_req && mem_done) begin
        mem_req  <= 1'b0;
        mem_wr   <= 1'b0;
        mem_a    <= '0;
        mem_dout <= '0;
        mem_kind <= '0;
        mem_pc   <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_o    <= '0;
      wreg_o  <= 1'b0;
      wdata_o <= '0;
    end else if (rdy) begin
      if (accept && !(in_st || in_fence)) begin
        wd_o   <= in_wd;
        wreg_o <= in_wreg;
        if (in_ld)
          wdata_o <= ext(fwd ? fwd_data : mem_din,
                         in_size, in_uns);
        else
          wdata_o <= in_wdata;
      end else begin
        wd_o   <= '0;
        wreg_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: vector table for single-cycle ops,
// hand sequences for buffer fill, hazard, fence and reset.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_valid, in_ld, in_st, in_fence;
  logic [1:0]  in_size;
  logic        in_uns;
  logic [31:0] in_addr, in_sdata, in_wdata, in_pc;
  logic [4:0]  in_wd;
  logic        in_wreg;
  logic        mem_busy, mem_done;
  logic [31:0] mem_din;
  logic        mem_req, mem_wr;
  logic [16:0] mem_a;
  logic [31:0] mem_dout, mem_pc;
  logic [3:0]  mem_kind;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq;
  logic [2:0]  sb_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_valid(in_valid), .in_ld(in_ld), .in_st(in_st),
    .in_fence(in_fence), .in_size(in_size), .in_uns(in_uns),
    .in_addr(in_addr), .in_sdata(in_sdata), .in_wd(in_wd),
    .in_wreg(in_wreg), .in_wdata(in_wdata), .in_pc(in_pc),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_din(mem_din),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_a(mem_a),
    .mem_dout(mem_dout), .mem_kind(mem_kind), .mem_pc(mem_pc),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq(stallreq), .sb_count(sb_count)
  );

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        e_wreg;
    logic [4:0]  e_wd;
    logic        chk_d;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(
    input logic [2:0] op, input logic [1:0] sz,
    input logic uns, input logic [31:0] addr,
    input logic [31:0] sdata, input logic [4:0] wd,
    input logic wreg, input logic [31:0] wdata,
    input logic e_wreg, input logic [4:0] e_wd,
    input logic chk_d, input logic [31:0] e_data,
    input logic [2:0] e_cnt
  );
    vec_t v;
    v.op = op; v.sz = sz; v.uns = uns;
    v.addr = addr; v.sdata = sdata; v.wd = wd;
    v.wreg = wreg; v.wdata = wdata;
    v.e_wreg = e_wreg; v.e_wd = e_wd;
    v.chk_d = chk_d; v.e_data = e_data; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    in_valid = 0; in_ld = 0; in_st = 0; in_fence = 0;
    in_size = 0; in_uns = 0; in_addr = 0; in_sdata = 0;
    in_wd = 0; in_wreg = 0; in_wdata = 0; in_pc = 0;
  endtask

  task automatic drive(input logic [2:0] op,
                       input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr,
                       input logic [31:0] sdata,
                       input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata);
    in_valid = 1;
    {in_ld, in_st, in_fence} = op;
    in_size = sz; in_uns = uns; in_addr = addr;
    in_sdata = sdata; in_wd = wd; in_wreg = wreg;
    in_wdata = wdata; in_pc = addr + 32'h1000;
  endtask

  task automatic do_reset();
    idle_in();
    rdy = 1; mem_busy = 0; mem_done = 0; mem_din = 0;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_wreg", 32'(wreg_o), 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_cnt", 32'(sb_count), 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
  endtask

  // Waits for a request, checks it, answers with one done cycle.
  task automatic serve(input logic [31:0] ea, input logic ewr,
                       input logic [3:0] ekind,
                       input logic [31:0] edout,
                       input logic [31:0] din,
                       input logic estall);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_seen", 32'(mem_req), 1);
    chk("mem_a", 32'(mem_a), ea);
    chk("mem_wr", 32'(mem_wr), 32'(ewr));
    chk("mem_kind", 32'(mem_kind), 32'(ekind));
    if (ewr) chk("mem_dout", mem_dout, edout);
    mem_done = 1; mem_din = din;
    @(negedge clk);
    chk("stall_done", 32'(stallreq), 32'(estall));
    @(posedge clk); #1;
    mem_done = 0; mem_din = 0;
    chk("req_clr", 32'(mem_req), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(3'b000, 2, 0, 0, 0, 5, 1, 32'h1234,
                 1, 5, 1, 32'h1234, 0);
    tbl[1]  = mk(3'b010, 2, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0,
                 0, 0, 0, 0, 1);
    tbl[2]  = mk(3'b100, 0, 0, 32'h100, 0, 7, 1, 0,
                 1, 7, 1, 32'hFFFFFFEF, 1);
    tbl[3]  = mk(3'b100, 0, 1, 32'h100, 0, 7, 1, 0,
                 1, 7, 1, 32'h000000EF, 1);
    tbl[4]  = mk(3'b100, 1, 0, 32'h100, 0, 7, 1, 0,
                 1, 7, 1, 32'hFFFFBEEF, 1);
    tbl[5]  = mk(3'b100, 1, 1, 32'h100, 0, 7, 1, 0,
                 1, 7, 1, 32'h0000BEEF, 1);
    tbl[6]  = mk(3'b100, 2, 0, 32'h100, 0, 7, 1, 0,
                 1, 7, 1, 32'hDEADBEEF, 1);
    tbl[7]  = mk(3'b010, 1, 0, 32'h200, 32'h00008001, 0, 0, 0,
                 0, 0, 0, 0, 2);
    tbl[8]  = mk(3'b100, 1, 0, 32'h200, 0, 8, 1, 0,
                 1, 8, 1, 32'hFFFF8001, 2);
    tbl[9]  = mk(3'b010, 2, 0, 32'h200, 32'h11112222, 0, 0, 0,
                 0, 0, 0, 0, 3);
    tbl[10] = mk(3'b100, 1, 0, 32'h200, 0, 9, 1, 0,
                 1, 9, 1, 32'h00002222, 3);
    tbl[11] = mk(3'b000, 2, 0, 0, 0, 3, 0, 32'h55,
                 0, 3, 1, 32'h55, 3);
    tbl[12] = mk(3'b010, 0, 0, 32'h300, 32'hFFFFFF7F, 0, 0, 0,
                 0, 0, 0, 0, 4);
    tbl[13] = mk(3'b100, 0, 0, 32'h300, 0, 10, 1, 0,
                 1, 10, 1, 32'h0000007F, 4);

    do_reset();

    // single-cycle ops with the controller busy: no memory traffic
    mem_busy = 1;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].op, tbl[i].sz, tbl[i].uns, tbl[i].addr,
            tbl[i].sdata, tbl[i].wd, tbl[i].wreg, tbl[i].wdata);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), 32'(stallreq), 0);
      chk($sformatf("v%0d_req", i), 32'(mem_req), 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_wreg", i), 32'(wreg_o),
          32'(tbl[i].e_wreg));
      chk($sformatf("v%0d_wd", i), 32'(wd_o), 32'(tbl[i].e_wd));
      if (tbl[i].chk_d)
        chk($sformatf("v%0d_data", i), wdata_o, tbl[i].e_data);
      chk($sformatf("v%0d_cnt", i), 32'(sb_count),
          32'(tbl[i].e_cnt));
    end
    idle_in();

    // rdy low freezes outputs
    do_reset();
    mem_busy = 1;
    drive(3'b000, 2, 0, 0, 0, 5, 1, 32'h77);
    @(posedge clk); #1;
    rdy = 0;
    drive(3'b010, 2, 0, 32'h80, 32'h1, 8, 1, 32'h99);
    @(posedge clk); #1;
    chk("frz_wd", 32'(wd_o), 5);
    chk("frz_wreg", 32'(wreg_o), 1);
    chk("frz_cnt", 32'(sb_count), 0);
    rdy = 1;
    idle_in();
    @(posedge clk); #1;
    chk("unfrz_wreg", 32'(wreg_o), 0);

    // buffer fill, fifth store waits for a pop
    do_reset();
    mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      drive(3'b010, 2, 0, 32'h400 + 4 * i, 32'hA0 + i, 0, 0, 0);
      @(negedge clk);
      chk("fill_stall", 32'(stallreq), 0);
      @(posedge clk); #1;
    end
    chk("fill_cnt", 32'(sb_count), 4);
    drive(3'b010, 2, 0, 32'h410, 32'hA4, 0, 0, 0);
    repeat (2) begin
      @(negedge clk);
      chk("full_stall", 32'(stallreq), 1);
      chk("full_noreq", 32'(mem_req), 0);
      @(posedge clk); #1;
    end
    mem_busy = 0;
    serve(32'h400, 1, 4'b0100, 32'hA0, 0, 0);
    idle_in();
    chk("refill_cnt", 32'(sb_count), 4);
    for (int j = 1; j < 5; j++)
      serve(32'h400 + 4 * j, 1, 4'b0100, 32'hA0 + j, 0, 0);
    chk("drained_cnt", 32'(sb_count), 0);

    // partial overlap: drain the store, then read
    do_reset();
    mem_busy = 1;
    drive(3'b010, 1, 0, 32'h102, 32'h5555, 0, 0, 0);
    @(posedge clk); #1;
    drive(3'b100, 2, 0, 32'h100, 0, 9, 1, 0);
    repeat (2) begin
      @(negedge clk);
      chk("haz_stall", 32'(stallreq), 1);
      chk("haz_noreq", 32'(mem_req), 0);
      @(posedge clk); #1;
    end
    mem_busy = 0;
    serve(32'h102, 1, 4'b0010, 32'h5555, 0, 1);
    serve(32'h100, 0, 4'b0100, 0, 32'hAABBCCDD, 0);
    idle_in();
    chk("haz_data", wdata_o, 32'hAABBCCDD);
    chk("haz_wreg", 32'(wreg_o), 1);
    chk("haz_wd", 32'(wd_o), 9);

    // fence waits for an empty buffer
    do_reset();
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      drive(3'b010, 2, 0, 32'h500 + 4 * i, 32'hC0 + i, 0, 0, 0);
      @(posedge clk); #1;
    end
    drive(3'b001, 2, 0, 0, 0, 6, 1, 32'h1);
    @(negedge clk);
    chk("fence_stall", 32'(stallreq), 1);
    @(posedge clk); #1;
    mem_busy = 0;
    for (int i = 0; i < 3; i++)
      serve(32'h500 + 4 * i, 1, 4'b0100, 32'hC0 + i, 0, 1);
    @(negedge clk);
    chk("fence_go", 32'(stallreq), 0);
    chk("fence_cnt", 32'(sb_count), 0);
    @(posedge clk); #1;
    idle_in();
    chk("fence_wreg", 32'(wreg_o), 0);
    chk("fence_wd", 32'(wd_o), 0);

    // reset during a read; load beats the pending drain
    do_reset();
    mem_busy = 1;
    drive(3'b010, 2, 0, 32'h700, 32'h1, 0, 0, 0);
    @(posedge clk); #1;
    drive(3'b100, 0, 0, 32'h600, 0, 4, 1, 0);
    mem_busy = 0;
    @(posedge clk); #1;
    chk("prio_req", 32'(mem_req), 1);
    chk("prio_wr", 32'(mem_wr), 0);
    chk("prio_a", 32'(mem_a), 32'h600);
    chk("prio_cnt", 32'(sb_count), 1);
    #2 rst = 0;
    #1;
    chk("arst_req", 32'(mem_req), 0);
    chk("arst_cnt", 32'(sb_count), 0);
    @(negedge clk);
    rst = 1;
    serve(32'h600, 0, 4'b0001, 0, 32'h00000080, 0);
    idle_in();
    chk("rl_data", wdata_o, 32'hFFFFFF80);
    chk("rl_wreg", 32'(wreg_o), 1);
    chk("rl_wd", 32'(wd_o), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
